// File: rtl/ysyx_23060286_ifu.sv
// Instruction fetch unit: keeps the PC, issues one outstanding 32-bit fetch at a time and hands
// {inst, pc, err} to decode over valid/ready. Redirects from execute replace the PC and squash stale fetches.
module ysyx_23060286_ifu #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data,
  input  logic            mem_resp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_err,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     fetch_cnt
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_drop;
  logic            r_inst_valid;
  logic [XLEN-1:0] r_inst;
  logic [XLEN-1:0] r_inst_pc;
  logic            r_inst_err;
  logic [31:0]     r_fetch_cnt;

  state_t          w_state_nxt;
  logic [XLEN-1:0] w_pc_nxt;
  logic            w_drop_nxt;
  logic            w_inst_valid_nxt;
  logic [XLEN-1:0] w_inst_nxt;
  logic [XLEN-1:0] w_inst_pc_nxt;
  logic            w_inst_err_nxt;
  logic [31:0]     w_fetch_cnt_nxt;

  logic            w_req_fire;
  logic [XLEN-1:0] w_redirect_pc;
  logic [XLEN-1:0] w_pc_plus4;

  assign mem_req_valid = (r_state == S_REQ) && !rst;
  assign mem_req_addr  = r_pc;
  assign inst_valid    = r_inst_valid;
  assign inst          = r_inst;
  assign inst_pc       = r_inst_pc;
  assign inst_err      = r_inst_err;
  assign fetch_cnt     = r_fetch_cnt;

  assign w_req_fire    = mem_req_valid && mem_req_ready;
  assign w_redirect_pc = redirect_pc & ~{{(XLEN-2){1'b0}}, 2'b11};
  assign w_pc_plus4    = r_pc + {{(XLEN-3){1'b0}}, 3'd4};

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_drop_nxt       = r_drop;
    w_inst_valid_nxt = r_inst_valid;
    w_inst_nxt       = r_inst;
    w_inst_pc_nxt    = r_inst_pc;
    w_inst_err_nxt   = r_inst_err;
    w_fetch_cnt_nxt  = r_fetch_cnt;

    case (r_state)
      S_REQ: begin
        if (redirect_valid) w_pc_nxt = w_redirect_pc;
        // A request accepted in the same cycle as a redirect targets the old PC; mark it stale.
        if (w_req_fire) begin
          w_state_nxt = S_WAIT;
          w_drop_nxt  = redirect_valid;
        end
      end
      S_WAIT: begin
        if (redirect_valid) w_pc_nxt = w_redirect_pc;
        if (mem_resp_valid) begin
          if (r_drop || redirect_valid) begin
            w_drop_nxt  = 1'b0;
            w_state_nxt = S_REQ;
          end else begin
            w_inst_valid_nxt = 1'b1;
            w_inst_nxt       = mem_resp_err ? '0 : mem_resp_data;
            w_inst_err_nxt   = mem_resp_err;
            w_inst_pc_nxt    = r_pc;
            w_state_nxt      = S_HOLD;
          end
        end else if (redirect_valid) begin
          w_drop_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        if (inst_ready) begin
          w_inst_valid_nxt = 1'b0;
          w_fetch_cnt_nxt  = r_fetch_cnt + 32'd1;
          w_pc_nxt         = redirect_valid ? w_redirect_pc : w_pc_plus4;
          w_state_nxt      = S_REQ;
        end else if (redirect_valid) begin
          w_inst_valid_nxt = 1'b0;
          w_pc_nxt         = w_redirect_pc;
          w_state_nxt      = S_REQ;
        end
      end
      default: begin
        w_state_nxt = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_REQ;
      r_pc         <= RESET_PC;
      r_drop       <= 1'b0;
      r_inst_valid <= 1'b0;
      r_inst       <= '0;
      r_inst_pc    <= '0;
      r_inst_err   <= 1'b0;
      r_fetch_cnt  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_drop       <= w_drop_nxt;
      r_inst_valid <= w_inst_valid_nxt;
      r_inst       <= w_inst_nxt;
      r_inst_pc    <= w_inst_pc_nxt;
      r_inst_err   <= w_inst_err_nxt;
      r_fetch_cnt  <= w_fetch_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_ysyx_23060286_ifu.sv
// Directed bench for the fetch unit: the bench plays both memory and decode cycle by cycle.
module tb_ysyx_23060286_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        mem_resp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_err;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_cnt;

  int checks = 0;
  int errors = 0;

  ysyx_23060286_ifu #(.XLEN(32), .RESET_PC(32'h8000_0000)) dut (
    .clk(clk), .rst(rst),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_err(mem_resp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .inst_err(inst_err), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0; mem_resp_err = 1'b0;
    inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step(); step();
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", mem_req_valid); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %b expected 0", inst_valid); end
    checks++; if (fetch_cnt !== 32'd0) begin errors++; $display("FAIL reset_fetch_cnt: got %h expected 0", fetch_cnt); end
    checks++; if ({inst, inst_pc, inst_err} !== 65'd0) begin errors++; $display("FAIL reset_inst_regs: got %h %h %b expected 0", inst, inst_pc, inst_err); end
    rst = 1'b0;
    #1;
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0000) begin errors++; $display("FAIL reset_first_req: got %b %h expected 1 80000000", mem_req_valid, mem_req_addr); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_addr;
    for (int i = 0; i < 3; i++) begin
      exp_addr = 32'h8000_0000 + 32'(4 * i);
      checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== exp_addr) begin errors++; $display("FAIL seq_req_%0d: got %b %h expected 1 %h", i, mem_req_valid, mem_req_addr, exp_addr); end
      mem_req_ready = 1'b1; step(); mem_req_ready = 1'b0;
      checks++; if (mem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL seq_wait_%0d: got req %b inst_valid %b expected 0 0", i, mem_req_valid, inst_valid); end
      mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0013 + 32'(i << 20); step(); mem_resp_valid = 1'b0;
      checks++; if (inst_valid !== 1'b1 || inst !== 32'h0000_0013 + 32'(i << 20) || inst_pc !== exp_addr || inst_err !== 1'b0) begin
        errors++; $display("FAIL seq_inst_%0d: got %b %h %h %b expected 1 %h %h 0", i, inst_valid, inst, inst_pc, inst_err, 32'h0000_0013 + 32'(i << 20), exp_addr); end
      inst_ready = 1'b1; step(); inst_ready = 1'b0;
      checks++; if (inst_valid !== 1'b0 || fetch_cnt !== 32'(i + 1)) begin errors++; $display("FAIL seq_accept_%0d: got %b cnt %0d expected 0 cnt %0d", i, inst_valid, fetch_cnt, i + 1); end
    end
  endtask

  task automatic test_hold_stall();
    mem_req_ready = 1'b1; step(); mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 32'h00A0_0093; step(); mem_resp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (inst_valid !== 1'b1 || inst !== 32'h00A0_0093 || inst_pc !== 32'h8000_000C || mem_req_valid !== 1'b0 || mem_req_addr !== 32'h8000_000C) begin
        errors++; $display("FAIL hold_stable_%0d: got %b %h %h req %b %h expected 1 00a00093 8000000c req 0 8000000c", i, inst_valid, inst, inst_pc, mem_req_valid, mem_req_addr); end
    end
    inst_ready = 1'b1; step(); inst_ready = 1'b0;
    checks++; if (fetch_cnt !== 32'd4 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0010) begin errors++; $display("FAIL hold_release: got cnt %0d req %b %h expected 4 1 80000010", fetch_cnt, mem_req_valid, mem_req_addr); end
  endtask

  task automatic test_redirect_hold_accept();
    mem_req_ready = 1'b1; step(); mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 32'h0010_0073; step(); mem_resp_valid = 1'b0;
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_0010) begin errors++; $display("FAIL rh_inst: got %b %h expected 1 80000010", inst_valid, inst_pc); end
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_0200; step();
    inst_ready = 1'b0; redirect_valid = 1'b0;
    checks++; if (fetch_cnt !== 32'd5 || inst_valid !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0200) begin
      errors++; $display("FAIL rh_next: got cnt %0d iv %b req %b %h expected 5 0 1 80000200", fetch_cnt, inst_valid, mem_req_valid, mem_req_addr); end
  endtask

  task automatic test_redirect_wait();
    mem_req_ready = 1'b1; step(); mem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0102; step(); redirect_valid = 1'b0;
    checks++; if (mem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL rw_waiting: got req %b iv %b expected 0 0", mem_req_valid, inst_valid); end
    mem_resp_valid = 1'b1; mem_resp_data = 32'hDEAD_BEEF; step(); mem_resp_valid = 1'b0;
    checks++; if (inst_valid !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0100 || fetch_cnt !== 32'd5) begin
      errors++; $display("FAIL rw_stale: got iv %b req %b %h cnt %0d expected 0 1 80000100 5", inst_valid, mem_req_valid, mem_req_addr, fetch_cnt); end
  endtask

  task automatic test_redirect_corners();
    // handshake and redirect in the same REQ cycle
    mem_req_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_0300; step();
    mem_req_ready = 1'b0; redirect_valid = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 32'h1111_1111; step(); mem_resp_valid = 1'b0;
    checks++; if (inst_valid !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0300) begin errors++; $display("FAIL rc_req_fire: got iv %b req %b %h expected 0 1 80000300", inst_valid, mem_req_valid, mem_req_addr); end
    // redirect coinciding with the response in WAIT
    mem_req_ready = 1'b1; step(); mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 32'h3333_3333; redirect_valid = 1'b1; redirect_pc = 32'h8000_0400; step();
    mem_resp_valid = 1'b0; redirect_valid = 1'b0;
    checks++; if (inst_valid !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0400) begin errors++; $display("FAIL rc_same_cycle: got iv %b req %b %h expected 0 1 80000400", inst_valid, mem_req_valid, mem_req_addr); end
    // the following fetch must not be discarded
    mem_req_ready = 1'b1; step(); mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 32'h2222_2222; step(); mem_resp_valid = 1'b0;
    checks++; if (inst_valid !== 1'b1 || inst !== 32'h2222_2222 || inst_pc !== 32'h8000_0400) begin errors++; $display("FAIL rc_drop_cleared: got %b %h %h expected 1 22222222 80000400", inst_valid, inst, inst_pc); end
    inst_ready = 1'b1; step(); inst_ready = 1'b0;
    checks++; if (fetch_cnt !== 32'd6 || mem_req_addr !== 32'h8000_0404) begin errors++; $display("FAIL rc_accept: got cnt %0d addr %h expected 6 80000404", fetch_cnt, mem_req_addr); end
  endtask

  task automatic test_fetch_error();
    mem_req_ready = 1'b1; step(); mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 32'hFFFF_FFFF; mem_resp_err = 1'b1; step();
    mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
    checks++; if (inst_valid !== 1'b1 || inst !== 32'd0 || inst_err !== 1'b1 || inst_pc !== 32'h8000_0404) begin
      errors++; $display("FAIL err_inst: got %b %h %b %h expected 1 00000000 1 80000404", inst_valid, inst, inst_err, inst_pc); end
    inst_ready = 1'b1; step(); inst_ready = 1'b0;
    checks++; if (fetch_cnt !== 32'd7 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0408) begin errors++; $display("FAIL err_next: got cnt %0d req %b %h expected 7 1 80000408", fetch_cnt, mem_req_valid, mem_req_addr); end
    mem_req_ready = 1'b1; step(); mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0013; step(); mem_resp_valid = 1'b0;
    checks++; if (inst_err !== 1'b0 || inst !== 32'h0000_0013 || inst_pc !== 32'h8000_0408) begin errors++; $display("FAIL err_cleared: got %b %h %h expected 0 00000013 80000408", inst_err, inst, inst_pc); end
  endtask

  task automatic test_reset_in_hold();
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL rst_hold_pre: got %b expected 1", inst_valid); end
    rst = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h1234_5678; step();
    inst_ready = 1'b0; redirect_valid = 1'b0;
    checks++; if (inst_valid !== 1'b0 || fetch_cnt !== 32'd0 || mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_hold: got iv %b cnt %0d req %b expected 0 0 0", inst_valid, fetch_cnt, mem_req_valid); end
    rst = 1'b0; #1;
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0000) begin errors++; $display("FAIL rst_hold_req: got %b %h expected 1 80000000", mem_req_valid, mem_req_addr); end
  endtask

  task automatic test_pc_wrap();
    // stray response in REQ is ignored; un-accepted redirect retargets the request
    mem_resp_valid = 1'b1; mem_resp_data = 32'h5555_5555; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF; step();
    mem_resp_valid = 1'b0; redirect_valid = 1'b0;
    checks++; if (inst_valid !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_redirect: got iv %b req %b %h expected 0 1 fffffffc", inst_valid, mem_req_valid, mem_req_addr); end
    mem_req_ready = 1'b1; step(); mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_006F; step(); mem_resp_valid = 1'b0;
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC || inst !== 32'h0000_006F) begin errors++; $display("FAIL wrap_inst: got %b %h %h expected 1 fffffffc 0000006f", inst_valid, inst_pc, inst); end
    inst_ready = 1'b1; step(); inst_ready = 1'b0;
    checks++; if (mem_req_addr !== 32'h0000_0000 || fetch_cnt !== 32'd1) begin errors++; $display("FAIL wrap_pc: got %h cnt %0d expected 00000000 1", mem_req_addr, fetch_cnt); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_hold_stall();
    test_redirect_hold_accept();
    test_redirect_wait();
    test_redirect_corners();
    test_fetch_error();
    test_reset_in_hold();
    test_pc_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
